// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the boot ROM loader.
// Holds the loader state encoding, bus widths and the default load address.
package rom_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  // Memory byte address that receives ROM byte 0 unless overridden.
  localparam logic [ADDR_W-1:0] DEFAULT_LOAD_BASE = 32'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader: boot sequencer that copies the program ROM into main memory.
// Walks the combinational ROM one byte at a time, writes each byte through
// a valid/ready port, and keeps the CPU in reset until the byte flagged by
// rom_done has been accepted. A copy that runs MAX_BYTES bytes without
// seeing rom_done ends in a terminal error state.
// Optional build macro ROM_LOADER_CHECKSUM_EN adds a modulo-256 running sum
// of accepted bytes on the checksum output; without it checksum reads 0.
import rom_loader_pkg::*;

module rom_loader #(
  parameter logic [ADDR_W-1:0] LOAD_BASE  = DEFAULT_LOAD_BASE,
  parameter int                MAX_BYTES  = 65536,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_byte,
  input  logic              rom_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-1:0] bytes_written,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] MAX_BYTES_W = ADDR_W'(MAX_BYTES);

  state_t            state_reg;
  logic [ADDR_W-1:0] offset_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              mem_write_reg;
  logic              cpu_reset_reg;
  logic              load_done_reg;
  logic              load_error_reg;
  logic [ADDR_W-1:0] bytes_written_reg;
  logic              accept;

  // A write completes on any edge where the port is valid and memory is ready.
  assign accept = (state_reg == WRITE) && mem_ready;

  // Loader FSM: fetch one ROM byte, hold it on the write port until accepted,
  // then advance, finish on the flagged last byte, or stop at the byte limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      offset_reg        <= '0;
      last_reg          <= 1'b0;
      mem_address_reg   <= LOAD_BASE;
      mem_data_reg      <= '0;
      mem_write_reg     <= 1'b0;
      cpu_reset_reg     <= 1'b1;
      load_done_reg     <= 1'b0;
      load_error_reg    <= 1'b0;
      bytes_written_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (AUTO_START || start) begin
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          // ROM is combinational from rom_address, so the byte is valid now.
          mem_data_reg    <= rom_byte;
          mem_address_reg <= LOAD_BASE + offset_reg;
          last_reg        <= rom_done;
          mem_write_reg   <= 1'b1;
          state_reg       <= WRITE;
        end
        WRITE: begin
          if (accept) begin
            mem_write_reg <= 1'b0;
            if (bytes_written_reg < MAX_BYTES_W) begin
              bytes_written_reg <= bytes_written_reg + 1'b1;
            end
            if (last_reg) begin
              // Release the CPU on the same edge the load is reported done.
              cpu_reset_reg <= 1'b0;
              load_done_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (bytes_written_reg + 1'b1 == MAX_BYTES_W) begin
              load_error_reg <= 1'b1;
              state_reg      <= ERROR;
            end else begin
              offset_reg <= offset_reg + 1'b1;
              state_reg  <= FETCH;
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        ERROR: begin
          state_reg <= ERROR;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rom_address   = offset_reg;
  assign mem_address   = mem_address_reg;
  assign mem_data      = mem_data_reg;
  assign mem_write     = mem_write_reg;
  assign cpu_reset     = cpu_reset_reg;
  assign load_done     = load_done_reg;
  assign load_error    = load_error_reg;
  assign bytes_written = bytes_written_reg;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  // Running sum of accepted bytes; naturally frozen once the FSM stops writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= checksum_reg + mem_data_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule
